// File: rtl/pwm_output_stage.sv
// Output stage: drives 16 chip pins low, high, or with one shared 8-bit PWM waveform.
// Latency: 1 clk from counter or enable change to pin; period = 256*PRESCALE clks.
// Backpressure: none; free-running, inputs are synchronous register-file values.
// Option: define PWM_SHADOW_EN so that duty changes take effect only at a period boundary.
module pwm_output_stage #(
    parameter int PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // Prescaler width; at least one bit so PRESCALE=1 still yields a legal vector.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_cnt_d;
    logic [7:0]    pwm_cnt_q;
    logic [7:0]    pwm_cnt_d;
    logic [7:0]    duty_q;
    logic [15:0]   out_q;
    logic [15:0]   out_d;
    logic          period_start_q;
    logic          tick;
    logic          wrap;
    logic          pwm_high;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // One tick per PRESCALE clks; the PWM counter advances on ticks only.
    assign tick = (pre_cnt_q == PRE_MAX);
    assign wrap = tick && (pwm_cnt_q == 8'hFF);

    // Counter next-state: prescaler wraps at PRESCALE-1, PWM counter wraps 255 -> 0.
    always_comb begin
        pre_cnt_d = tick ? '0 : (pre_cnt_q + PW'(1));
        pwm_cnt_d = tick ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
    end

    // Prescaler, PWM counter and period marker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= 8'h00;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= wrap;
        end
    end

`ifdef PWM_SHADOW_EN
    // Duty shadow: sampled only at the period boundary so each period shows one clean pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= 8'h00;
        end else if (wrap) begin
            duty_q <= pwm_duty_cycle;
        end
    end
`else
    // Unshadowed duty: a write reaches the compare immediately, possibly mid-pulse.
    assign duty_q = pwm_duty_cycle;
`endif

    // 0xFF is treated as 100% so full duty never shows a one-clk low at cnt 255.
    assign pwm_high = (duty_q == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_q);

    // Per-pin select: disabled pins are low regardless of the PWM select bit.
    always_comb begin
        out_d = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            out_d[i] = en_out[i] ? (en_pwm[i] ? pwm_high : 1'b1) : 1'b0;
        end
    end

    // Registered pins; reset pulls every output low immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 16'h0000;
        end else begin
            out_q <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench: table of enable/duty configurations measured over one PWM period,
// plus hand sequences for reset, static hold, prescaled period, duty change and mid-period reset.
module tb_pwm_output_stage;

    logic        clk;
    logic        rst;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out1;
    logic        ps1;
    logic [15:0] out13;
    logic        ps13;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_output_stage #(.PRESCALE(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out1),
        .period_start    (ps1)
    );

    pwm_output_stage #(.PRESCALE(13)) dut13 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out13),
        .period_start    (ps13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
        logic [15:0] pwm_mask;     // pins expected to carry the PWM waveform
        int          pwm_hi;       // high clks per period on those pins
        logic [15:0] static_mask;  // pins expected constantly high
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        en_reg_out_7_0  = eo[7:0];
        en_reg_out_15_8 = eo[15:8];
        en_reg_pwm_7_0  = ep[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        pwm_duty_cycle  = d;
    endtask

    // Always advances at least one clk before looking, so a pulse already showing is skipped.
    task automatic wait_ps(input bit use13, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((use13 ? ps13 : ps1) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, int'(ok), 1);
    endtask

    initial begin
        int hi_cnt[16];
        int ps_cnt;
        int bad;
        int hi0;
        int last_ps;
        int found;
        int exp_hi;

        //            en_out    en_pwm    duty   pwm_mask  hi   static
        vecs[0] = '{16'hFFFF, 16'hFFFF, 8'h80, 16'hFFFF, 128, 16'h0000};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'hFFFF,   0, 16'h0000};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF, 256, 16'h0000};
        vecs[3] = '{16'h00FF, 16'h0000, 8'h80, 16'h0000,   0, 16'h00FF};
        vecs[4] = '{16'h0F0F, 16'h00FF, 8'h40, 16'h000F,  64, 16'h0F00};
        vecs[5] = '{16'hFFFF, 16'hAAAA, 8'h01, 16'hAAAA,   1, 16'h5555};
        vecs[6] = '{16'hF0F0, 16'hFFFF, 8'hFE, 16'hF0F0, 254, 16'h0000};

        // Reset with every input at 0xFF: pins low, no period marker.
        rst = 1'b1;
        drive(16'hFFFF, 16'hFFFF, 8'hFF);
        repeat (3) @(negedge clk);
        check("rst_out", int'(out1), 0);
        check("rst_ps", int'(ps1), 0);
        check("rst_out13", int'(out13), 0);
        rst = 1'b0;
        @(negedge clk);
`ifdef PWM_SHADOW_EN
        check("release_out", int'(out1), 16'h0000);
`else
        check("release_out", int'(out1), 16'hFFFF);
`endif

        // Static-high half with PWM off: no toggling over 512 clks.
        drive(16'h00FF, 16'h0000, 8'h80);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            if (out1 !== 16'h00FF) bad++;
        end
        check("static_512_bad_samples", bad, 0);

        // Table: one full period per configuration, high clks counted per pin.
        foreach (vecs[v]) begin
            drive(vecs[v].en_out, vecs[v].en_pwm, vecs[v].duty);
            wait_ps(1'b0, 600, $sformatf("vec%0d", v));
            foreach (hi_cnt[i]) hi_cnt[i] = 0;
            ps_cnt = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                for (int i = 0; i < 16; i++) if (out1[i] === 1'b1) hi_cnt[i]++;
                if (ps1 === 1'b1) ps_cnt++;
            end
            for (int i = 0; i < 16; i++) begin
                exp_hi = vecs[v].pwm_mask[i] ? vecs[v].pwm_hi : (vecs[v].static_mask[i] ? 256 : 0);
                check($sformatf("vec%0d_pin%0d_high", v, i), hi_cnt[i], exp_hi);
            end
            check($sformatf("vec%0d_ps_count", v), ps_cnt, 1);
        end

        // Duty 0x20 -> 0xE0 written while pwm_cnt = 100.
        drive(16'hFFFF, 16'hFFFF, 8'h20);
        wait_ps(1'b0, 600, "duty_chg_align");
        wait_ps(1'b0, 600, "duty_chg_start");
        hi0 = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (out1[0] === 1'b1) hi0++;
            if (k == 99) pwm_duty_cycle = 8'hE0;
        end
`ifdef PWM_SHADOW_EN
        check("duty_chg_cur_period", hi0, 32);
`else
        check("duty_chg_cur_period", hi0, 32 + 124);
`endif
        check("duty_chg_period_end", int'(ps1), 1);
        hi0 = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (out1[0] === 1'b1) hi0++;
        end
        check("duty_chg_next_period", hi0, 224);

        // Reset pulse at pwm_cnt = 150 while pins are high.
        pwm_duty_cycle = 8'hC8;
        wait_ps(1'b0, 600, "midrst_align");
        repeat (150) @(negedge clk);
        check("midrst_out_before", int'(out1), 16'hFFFF);
        rst = 1'b1;
        #1;
        check("midrst_out_async", int'(out1), 0);
        check("midrst_ps_async", int'(ps1), 0);
        @(negedge clk);
        rst = 1'b0;
        found = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
`ifdef PWM_SHADOW_EN
            if (n == 1) check("midrst_first_out", int'(out1), 16'h0000);
`else
            if (n == 1) check("midrst_first_out", int'(out1), 16'hFFFF);
`endif
            if (ps1 === 1'b1) begin
                found = n;
                break;
            end
        end
        check("midrst_first_ps_clks", found, 256);

        // PRESCALE=13, duty 0x40: period 3328 clks, high 832 clks.
        drive(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps(1'b1, 4000, "pre13_align");
        hi0 = 0;
        ps_cnt = 0;
        last_ps = -1;
        for (int k = 0; k < 3328; k++) begin
            @(negedge clk);
            if (out13[0] === 1'b1) hi0++;
            if (ps13 === 1'b1) begin
                ps_cnt++;
                last_ps = k;
            end
        end
        check("pre13_high_clks", hi0, 832);
        check("pre13_ps_count", ps_cnt, 1);
        check("pre13_ps_spacing", last_ps + 1, 3328);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
